// File: rtl/tdc_multi_ch.sv
// rtl/tdc_multi_ch.sv - multi-channel TDC, round-robin arbitration into a shared show-ahead hit FIFO
// Optional build macro TDC_FALLING_EDGE_EN: also time-stamp falling edges (edge bit = 0).
module tdc_multi_ch #(
  parameter int CHANNELS   = 4,
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   BUS_CLK,
  input  logic                   BUS_RST,
  input  logic                   TS_RESET,
  input  logic [CHANNELS-1:0]    EN,
  input  logic [CHANNELS-1:0]    SIGNAL,
  output logic [CH_W+TS_WIDTH:0] DATA_OUT,
  output logic                   DATA_VALID,
  input  logic                   DATA_READY,
  output logic [7:0]             LOST_CNT,
  output logic                   FIFO_FULL
);
  localparam int DW = CH_W + 1 + TS_WIDTH;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [TS_WIDTH-1:0] ts_cnt;

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST)       ts_cnt <= '0;
    else if (TS_RESET) ts_cnt <= '0;
    else               ts_cnt <= ts_cnt + TS_WIDTH'(1);
  end

  logic [CHANNELS-1:0] sync1, sync2, prev;
  logic [1:0]          mask_cnt;
  logic                mask_done;

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      mask_cnt <= '0;
    end else begin
      sync1 <= SIGNAL;
      sync2 <= sync1;
      prev  <= sync2;
      if (mask_cnt != 2'd3) mask_cnt <= mask_cnt + 2'd1;
    end
  end

  // Inputs already high at reset release show up as edges; the mask hides them.
  assign mask_done = (mask_cnt == 2'd3);

  logic [CHANNELS-1:0] rise, fall, hit, edge_bit;
  assign rise = sync2 & ~prev;
`ifdef TDC_FALLING_EDGE_EN
  assign fall     = ~sync2 & prev;
  assign edge_bit = sync2;
`else
  assign fall     = '0;
  assign edge_bit = '1;
`endif
  assign hit = (rise | fall) & EN & {CHANNELS{mask_done}};

  logic [CHANNELS-1:0] pend;
  logic [TS_WIDTH:0]   hold [CHANNELS];
  logic [CH_W-1:0]     rr_ptr, grant_ch;
  logic                grant_vld, pop, wr_ok;

  assign pop   = DATA_VALID & DATA_READY;
  assign wr_ok = ~FIFO_FULL | pop;

  // Lowest pending index at/after the pointer, else lowest pending overall.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (pend[c] && (c >= int'(rr_ptr))) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(c);
      end
    end
    if (!grant_vld) begin
      for (int c = CHANNELS - 1; c >= 0; c--) begin
        if (pend[c]) begin
          grant_vld = 1'b1;
          grant_ch  = CH_W'(c);
        end
      end
    end
    if (!wr_ok) grant_vld = 1'b0;
  end

  logic [CHANNELS-1:0] gnt_oh, drop;
  logic [4:0]          n_drop;
  logic [8:0]          lost_sum;

  always_comb begin
    gnt_oh = '0;
    if (grant_vld) gnt_oh[grant_ch] = 1'b1;
  end

  assign drop = hit & pend & ~gnt_oh;

  always_comb begin
    n_drop = '0;
    for (int c = 0; c < CHANNELS; c++) n_drop = n_drop + 5'(drop[c]);
  end

  assign lost_sum = {1'b0, LOST_CNT} + {4'd0, n_drop};

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      pend     <= '0;
      rr_ptr   <= '0;
      LOST_CNT <= '0;
      for (int c = 0; c < CHANNELS; c++) hold[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        // A grant frees the slot in the same cycle, so a coincident hit reloads it.
        if (hit[c] && (!pend[c] || gnt_oh[c])) begin
          pend[c] <= 1'b1;
          hold[c] <= {edge_bit[c], ts_cnt};
        end else if (gnt_oh[c]) begin
          pend[c] <= 1'b0;
        end
      end
      if (TS_RESET)               LOST_CNT <= '0;
      else if (lost_sum > 9'd255) LOST_CNT <= 8'd255;
      else                        LOST_CNT <= lost_sum[7:0];
      if (grant_vld) begin
        if (grant_ch == CH_W'(CHANNELS - 1)) rr_ptr <= '0;
        else                                 rr_ptr <= grant_ch + CH_W'(1);
      end
    end
  end

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [DW-1:0] wdata;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          head_empty;

  assign wdata      = {grant_ch, hold[grant_ch]};
  assign count_nxt  = count + (AW+1)'(grant_vld) - (AW+1)'(pop);
  assign head_empty = (count == (AW+1)'(pop));

  always_ff @(posedge BUS_CLK) begin
    if (grant_vld) mem[wr_ptr] <= wdata;
  end

  // DATA_OUT mirrors mem[rd_ptr]; an empty FIFO forwards the write straight to it.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      DATA_VALID <= 1'b0;
      FIFO_FULL  <= 1'b0;
      DATA_OUT   <= '0;
    end else begin
      if (grant_vld) wr_ptr <= wr_ptr + AW'(1);
      if (pop)       rd_ptr <= rd_ptr + AW'(1);
      count      <= count_nxt;
      DATA_VALID <= (count_nxt != '0);
      FIFO_FULL  <= (count_nxt == (AW+1)'(FIFO_DEPTH));
      if (grant_vld && head_empty) DATA_OUT <= wdata;
      else if (pop)                DATA_OUT <= mem[rd_ptr + AW'(1)];
    end
  end

endmodule

// File: tb/tb_tdc_multi_ch.sv
// tb/tb_tdc_multi_ch.sv - self-checking bench for tdc_multi_ch with an edge/queue reference model
module tb_tdc_multi_ch;
  localparam int CH    = 4;
  localparam int TSW   = 4;
  localparam int DEPTH = 8;
  localparam int CHW   = 2;
  localparam int DW    = CHW + 1 + TSW;
`ifdef TDC_FALLING_EDGE_EN
  localparam int EPP = 2;
`else
  localparam int EPP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ts_reset = 1'b0;
  logic          ready = 1'b0;
  logic [CH-1:0] en = '1;
  logic [CH-1:0] sig = '0;
  logic [DW-1:0] dout;
  logic          dv, full;
  logic [7:0]    lost;

  int checks = 0;
  int failures = 0;

  tdc_multi_ch #(.CHANNELS(CH), .TS_WIDTH(TSW), .FIFO_DEPTH(DEPTH)) dut (
    .BUS_CLK(clk), .BUS_RST(rst), .TS_RESET(ts_reset), .EN(en), .SIGNAL(sig),
    .DATA_OUT(dout), .DATA_VALID(dv), .DATA_READY(ready), .LOST_CNT(lost), .FIFO_FULL(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a hit is SIGNAL changing between the samples taken 3 and 2 edges ago.
  logic [DW-1:0] mq[$];
  bit            pend_m [CH];
  logic [DW-1:0] hold_m [CH];
  int            ptr_m = 0, lost_m = 0, ts_m = 0, since_m = 0;
  logic [CH-1:0] s1 = '0, s2 = '0, s3 = '0;

  always @(posedge clk or posedge rst) begin
    bit pop, wok, r, f;
    int g, nlost, c2;
    if (rst) begin
      mq.delete();
      for (int c = 0; c < CH; c++) begin pend_m[c] = 0; hold_m[c] = '0; end
      ptr_m = 0; lost_m = 0; ts_m = 0; since_m = 0;
      s1 = '0; s2 = '0; s3 = '0;
    end else begin
      pop = (mq.size() != 0) && ready;
      wok = (mq.size() < DEPTH) || pop;
      g = -1;
      if (wok)
        for (int i = 0; i < CH; i++) begin
          c2 = (ptr_m + i) % CH;
          if (g < 0 && pend_m[c2]) g = c2;
        end
      if (pop) void'(mq.pop_front());
      if (g >= 0) begin
        mq.push_back(hold_m[g]);
        pend_m[g] = 0;
        ptr_m = (g + 1) % CH;
      end
      if (since_m < 100) since_m++;
      nlost = 0;
      for (int c = 0; c < CH; c++) begin
        r = s2[c] & ~s3[c];
`ifdef TDC_FALLING_EDGE_EN
        f = ~s2[c] & s3[c];
`else
        f = 1'b0;
`endif
        if ((r || f) && en[c] && since_m >= 4) begin
          if (pend_m[c]) nlost++;
          else begin
            pend_m[c] = 1;
            hold_m[c] = {CHW'(c), r, TSW'(ts_m)};
          end
        end
      end
      if (ts_reset) lost_m = 0;
      else lost_m = (lost_m + nlost > 255) ? 255 : lost_m + nlost;
      ts_m = ts_reset ? 0 : (ts_m + 1) % (1 << TSW);
      s3 = s2; s2 = s1; s1 = sig;
    end
  end

  always @(negedge clk) begin
    chk("valid", 32'(dv), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("data", 32'(dout), 32'(mq[0]));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("lost", 32'(lost), 32'(lost_m));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int cnt;
    logic [DW-1:0] w, w1, w2;
    logic [TSW-1:0] d;

    tick(2);
    chk("rst_valid", 32'(dv), 0);
    chk("rst_data", 32'(dout), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_lost", 32'(lost), 0);
    rst = 1'b0;
    tick(8);

    // Basic hit: ch2 sampled 5 edges after TS_RESET
    ts_reset = 1'b1; tick(1);
    ts_reset = 1'b0; tick(4);
    sig[2] = 1'b1;
    tick(3);
    chk("basic_lat_early", 32'(dv), 0);
    tick(1);
    chk("basic_lat_valid", 32'(dv), 1);
    chk("basic_word", 32'(dout), 32'h56);
    ready = 1'b1; tick(1);
    sig[2] = 1'b0; tick(10);

    // Simultaneous hits after a fresh reset (pointer 0)
    rst = 1'b1; sig = '0; tick(2);
    rst = 1'b0; tick(5);
    sig = 4'hF;
    tick(4);
    for (int i = 0; i < 4; i++) begin
      w = {CHW'(i), 1'b1, 4'd7};
      chk("simul_word", 32'(dout), 32'(w));
      tick(1);
    end
    sig = '0; tick(10);

    // Backpressure and overflow on ch0
    ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sig[0] = 1'b1; tick(2);
      sig[0] = 1'b0; tick(2);
    end
    tick(6);
    chk("ovf_full", 32'(full), 1);
    chk("ovf_valid", 32'(dv), 1);
    chk("ovf_lost", 32'(lost), 32'(12 * EPP - 9));
    chk("ovf_first_ch_edge", 32'(dout[DW-1:TSW]), 32'b001);
    for (int i = 0; i < 2; i++) begin
      sig[0] = 1'b1; tick(2);
      sig[0] = 1'b0; tick(2);
    end
    tick(4);
    chk("lost_pre_clear", 32'(lost), 32'(14 * EPP - 9));
    ts_reset = 1'b1; tick(1);
    ts_reset = 1'b0;
    chk("lost_cleared", 32'(lost), 0);
    ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (dv) begin
        cnt++;
        chk("drain_ch", 32'(dout[DW-1:TSW+1]), 0);
      end
      tick(1);
    end
    chk("drain_count", 32'(cnt), 9);

    // Timestamp wrap: hits at ts 15 then 0
    ts_reset = 1'b1; tick(1);
    ts_reset = 1'b0; tick(13);
    sig[1] = 1'b1; tick(1);
    sig[3] = 1'b1; tick(3);
    chk("wrap_ts15", 32'(dout), 32'h3F);
    tick(1);
    chk("wrap_ts0", 32'(dout), 32'h70);
    tick(6);

    // Reset mask: ch1 high through reset release
    rst = 1'b1; sig = 4'b0010; tick(3);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (dv) cnt++;
      tick(1);
    end
    chk("mask_no_word", 32'(cnt), 0);

    // Disabled channel toggling
    en = 4'b1110;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      sig[0] = 1'b1; tick(2);
      sig[0] = 1'b0; tick(2);
    end
    for (int i = 0; i < 8; i++) begin
      if (dv) cnt++;
      tick(1);
    end
    chk("en_no_word", 32'(cnt), 0);
    chk("en_lost", 32'(lost), 0);
    en = '1;
    sig[1] = 1'b0; tick(10);

    // 10-cycle pulse on ch1
    cnt = 0; w1 = '0; w2 = '0;
    for (int t = 0; t < 25; t++) begin
      if (t == 0)  sig[1] = 1'b1;
      if (t == 10) sig[1] = 1'b0;
      if (dv) begin
        if (cnt == 0) w1 = dout;
        else w2 = dout;
        cnt++;
      end
      tick(1);
    end
    chk("pulse_words", 32'(cnt), 32'(EPP));
    chk("pulse_first_ch_edge", 32'(w1[DW-1:TSW]), 32'b011);
`ifdef TDC_FALLING_EDGE_EN
    chk("pulse_second_ch_edge", 32'(w2[DW-1:TSW]), 32'b010);
    d = w2[TSW-1:0] - w1[TSW-1:0];
    chk("pulse_ts_diff", 32'(d), 10);
`endif

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdc_multi_ch.md
# tdc_multi_ch

A multi-channel time-to-digital converter core that time-stamps edges on `CHANNELS` asynchronous `SIGNAL` inputs against a free-running counter. Hits are arbitrated round-robin into one shared FIFO and presented on a valid/ready output port. It is the parametrised successor of the single-channel TDC DUT in the FPGA emulation top. It sits between the stimulus and `TS_RESET` generation in the firmware core and the readout serialiser.

## Interface
- `CHANNELS`, 4: number of input channels, 1..16.
- `TS_WIDTH`, 16: timestamp counter width, 4..32.
- `FIFO_DEPTH`, 8: shared hit FIFO depth, power of two, ≥2.
- `CH_W`, derived: max(1, $clog2(CHANNELS)).
- `BUS_CLK` input 1: single clock. All logic in this block is clocked by `BUS_CLK`.
- `BUS_RST` input 1: reset, asynchronous, active-high.
- `TS_RESET` input 1: synchronous clear of the timestamp and lost counters.
- `EN` input CHANNELS: per-channel capture enable.
- `SIGNAL` input CHANNELS: asynchronous hit inputs.
- `DATA_OUT` output CH_W+1+TS_WIDTH: hit word {channel, edge, timestamp}.
- `DATA_VALID` output 1: `DATA_OUT` holds a valid word.
- `DATA_READY` input 1: consumer accepts the word.
- `LOST_CNT` output 8: saturating count of dropped hits.
- `FIFO_FULL` output 1: the FIFO holds `FIFO_DEPTH` words.

## Operation
- **Timestamp counter.**
  - `ts_cnt` increments every cycle and wraps from 2^TS_WIDTH−1 to 0.
  - When `TS_RESET` is sampled high, `ts_cnt` is 0 after that edge. `LOST_CNT` is also cleared. `TS_RESET` does not flush the FIFO or the hold registers.
- **Front end (per channel).**
  - A 2-flop synchroniser feeds a `prev` register.
  - Rising edge is `sync2 & ~prev`.
  - An edge is qualified only when `EN[ch]` is high and the startup mask has expired.
- **Startup mask.** Edge detection is suppressed for 3 cycles after `BUS_RST` deasserts. A `SIGNAL` that is high at reset therefore produces no hit.
- **Hold register (per channel, one deep).**
  - A qualified edge loads {edge, ts_cnt} and sets `pend[ch]`.
  - Edge while `pend` is set and not granted in the same cycle: the hit is dropped and `LOST_CNT` increments, saturating at 255.
  - Edge in the same cycle as a grant on that channel: the new hit reloads the hold register and is not lost.
  - Clearing `EN` does not discard a pending hit.
- **Arbiter.**
  - Each cycle a write is possible when the FIFO is not full, or when it is full and popping in the same cycle.
  - When a write is possible, the arbiter grants the first pending channel at or after the round-robin pointer, wrapping at `CHANNELS`. The pointer then becomes grant+1 mod `CHANNELS`.
  - Pointer resets to 0.
- **FIFO.**
  - Show-ahead: `DATA_OUT` and `DATA_VALID` are registered.
  - A pop happens on `DATA_VALID & DATA_READY`.
  - Simultaneous push and pop when full is legal and the count is unchanged.
  - `DATA_OUT` is stable while `DATA_VALID & ~DATA_READY`.
- **Word format.** [TS_WIDTH+CH_W : TS_WIDTH+1] = channel index, [TS_WIDTH] = edge (1 = rising), [TS_WIDTH-1:0] = timestamp.

## Timing
- Reset values:
  - `DATA_VALID` = 0, `DATA_OUT` = 0, `FIFO_FULL` = 0, `LOST_CNT` = 0.
  - `ts_cnt` = 0, all `pend` = 0, synchronisers and `prev` = 0, pointer = 0.
- Hit latency:
  - `SIGNAL` is stable before edge k.
  - The synchroniser is at 1 after edge k+1, and the edge is detected during cycle k+1.
  - The hold register is loaded at k+2 with the `ts_cnt` value present during cycle k+1.
  - The FIFO write happens at k+3 if granted, and `DATA_VALID` = 1 after k+3.
- An edge detected in the cycle that `TS_RESET` is sampled takes the pre-clear `ts_cnt`.
- Assertion of `BUS_RST` mid-operation clears everything immediately, including FIFO contents.
- Pulses shorter than 2 `BUS_CLK` periods may be missed. This is not an error.

## Configuration
- `TDC_FALLING_EDGE_EN`:
  - Defined: falling edges (`~sync2 & prev`) are also captured, with edge bit = 0. A rising and a falling edge cannot coincide on one channel.
  - Undefined: only rising edges are captured, and the edge bit is constant 1.
  - The word width is the same in both builds.

## Test plan
- **Basic hit.** Defaults. Pulse `TS_RESET`, drive `SIGNAL[2]` high to be sampled 5 edges later → one word, ch=2, edge=1, ts=6, latency as specified.
- **Simultaneous hits.** `SIGNAL[3:0]` rise in the same cycle, pointer = 0 → words ch 0,1,2,3 on consecutive cycles, all with an identical timestamp.
- **Backpressure and overflow.**
  - `DATA_READY` = 0, 12 single-channel hits on channel 0, spaced 4 cycles apart → FIFO holds 8 words, `FIFO_FULL` = 1, 1 hit held, `LOST_CNT` = 3.
  - Release `DATA_READY` → 9 words in order.
- **Wrap and clear.**
  - `TS_WIDTH` = 4: hit at counter 15 then at 0 → ts 15 then 0.
  - `TS_RESET` with `LOST_CNT` = 5 → 0.
- **Reset mask and enable.**
  - `SIGNAL[1]` high through reset release → no word.
  - `EN[0]` = 0 and channel 0 toggles → no word, `LOST_CNT` unchanged.
- **Falling edges.** With `TDC_FALLING_EDGE_EN`, a 10-cycle pulse on ch 1 → two words, edge 1 then 0, timestamp difference 10. Without the macro → one word.
